mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports named as below.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 Reset_L  input  1  asynchronous active-low reset.
REQ-004 BusA  input  32  operand A from the ID/EX operand bus, shared with the ALU (dividend / multiplicand / MTHI-MTLO source).
REQ-005 BusB  input  32  operand B from the ID/EX operand bus, shared with the ALU (divisor / multiplier).
REQ-006 MDCtrl  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
REQ-007 Start  input  1  one-cycle strobe; the opcode and operands are valid in the same cycle.
REQ-008 Flush  input  1  aborts any in-flight operation.
REQ-009 Busy  output  1  high while an operation is in flight; the pipeline stalls on MFHI/MFLO while it is high.
REQ-010 Done  output  1  one-cycle pulse after HI/LO are updated by MULT/MULTU/DIV/DIVU.
REQ-011 HiLoOut  output  32  HI when MDCtrl=MFHI, otherwise LO; combinational from the registers; feeds the EX result mux beside the ALU output.

Function
REQ-012 The block SHALL use states IDLE, CALC and FIX, with a 5-bit iteration counter.
REQ-013 In IDLE, with Start=1 and MDCtrl in 000-011, the block SHALL latch |BusA| and |BusB| (signed ops) or raw values (unsigned ops), latch the result signs, clear the counter and enter CALC.
REQ-014 CALC SHALL perform one radix-2 step per cycle: shift-add multiply (64-bit product) or restoring divide (32-bit quotient and remainder).
REQ-015 CALC SHALL last exactly 32 cycles, then enter FIX.
REQ-016 FIX SHALL apply sign correction and write HI/LO:
- multiply: HI = product[63:32], LO = product[31:0];
- divide: LO = quotient, HI = remainder.
REQ-017 After FIX the block SHALL return to IDLE, and Done SHALL be 1 for exactly the following cycle.
REQ-018 Latency SHALL be fixed: HI/LO are visible 34 rising edges after the edge that samples Start, with Busy=1 for those 34 cycles.
REQ-019 Signed sign rules SHALL be:
- product and quotient are negative iff BusA[31]^BusB[31];
- remainder takes the sign of BusA.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0 (two's-complement wrap, no trap).
REQ-021 Divide by zero (DIV or DIVU) SHALL give LO=0xFFFFFFFF, HI=BusA as latched, with the same latency and no error flag.
REQ-022 MTHI/MTLO with Start=1 in IDLE SHALL write BusA into HI/LO at that edge, with no Busy and no Done.
REQ-023 MFHI/MFLO SHALL have no state effect; Start with MDCtrl 100/101 SHALL be ignored.
REQ-024 Start while Busy=1 SHALL be ignored, and the in-flight operation SHALL continue unchanged.
REQ-025 Flush=1 at any edge SHALL force IDLE, clear Busy and the counter, suppress Done, and leave HI/LO unchanged; Flush SHALL take priority over Start.
REQ-026 Flush arriving in the FIX cycle SHALL abort the write; HI/LO SHALL keep their prior values.
REQ-027 Operand changes on BusA/BusB after the Start edge SHALL NOT affect the result.

Reset
REQ-028 With Reset_L=0 the block SHALL immediately force: state IDLE, counter 0, Busy=0, Done=0, HI=0, LO=0, so HiLoOut=0.
REQ-029 Reset_L deassertion mid-operation SHALL leave the block in IDLE; the aborted operation never completes.

Verification
REQ-030 MULT BusA=0xFFFFFFFE (-2), BusB=0x00000003 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA; Done pulses once; Busy high for exactly 34 cycles.
REQ-031 MULTU BusA=0xFFFFFFFF, BusB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 DIV BusA=0xFFFFFFF9 (-7), BusB=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU BusA=7, BusB=0 -> LO=0xFFFFFFFF, HI=7.
REQ-033 MTLO 0x12345678, then MFLO -> HiLoOut=0x12345678 on the next cycle; Busy stays 0.
REQ-034 Start DIV, then a second Start at cycle 5 with different operands, then Flush at cycle 20 -> Busy=0 the next cycle, Done never pulses, HI/LO keep the MTLO/earlier values.
REQ-035 Reset_L pulsed low at cycle 10 of a MULT -> Busy=0, HI=LO=0 immediately; Done never pulses.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply and
// restoring divide, fixed 34-cycle latency, flushable from the pipeline.
module mult_div_unit (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [31:0] BusA,
    input  logic [31:0] BusB,
    input  logic [2:0]  MDCtrl,
    input  logic        Start,
    input  logic        Flush,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HiLoOut
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [2:0] OP_MFHI = 3'b100;
    localparam logic [2:0] OP_MTHI = 3'b110;
    localparam logic [2:0] OP_MTLO = 3'b111;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] hi, lo;

    logic [31:0] acc_hi, acc_lo, opnd;
    logic        is_div, q_neg, r_neg;

    logic        signed_op, start_md;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] prod_fixed;

    function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic take_abs);
        return (take_abs && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] negate32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] negate64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    assign signed_op = ~MDCtrl[0];
    assign start_md  = Start && !Flush && (state == IDLE) && !MDCtrl[2];
    assign mag_a     = magnitude(BusA, signed_op);
    assign mag_b     = magnitude(BusB, signed_op);

    // Multiply step: conditionally add multiplicand into the upper half, then shift right
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);

    // Divide step: bring the next dividend bit into the partial remainder and trial-subtract
    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift[31:0] - opnd;

    assign prod_fixed = negate64({acc_hi, acc_lo}, q_neg);

    assign Busy    = (state != IDLE);
    assign HiLoOut = (MDCtrl == OP_MFHI) ? hi : lo;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= IDLE;
            cnt   <= 5'd0;
            Done  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_nxt;
            Done  <= (state == FIX) && (cnt == 5'd1) && !Flush;
            cnt   <= (state_nxt == IDLE || state == IDLE) ? 5'd0 : cnt + 5'd1;
            if (!Flush && state == IDLE && Start) begin
                if (MDCtrl == OP_MTHI) hi <= BusA;
                if (MDCtrl == OP_MTLO) lo <= BusA;
            end
            if (!Flush && state == FIX && cnt == 5'd1) begin
                hi <= acc_hi;
                lo <= acc_lo;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_md) state_nxt = CALC;
            CALC:    if (cnt == 5'd31) state_nxt = FIX;
            FIX:     if (cnt == 5'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (Flush) state_nxt = IDLE;
    end

    // Datapath holds no reset: it is always reloaded by the Start that launches an operation
    always_ff @(posedge CLK) begin
        if (start_md) begin
            acc_hi <= 32'd0;
            acc_lo <= MDCtrl[1] ? mag_a : mag_b;
            opnd   <= MDCtrl[1] ? mag_b : mag_a;
            is_div <= MDCtrl[1];
            q_neg  <= signed_op && (BusA[31] ^ BusB[31]) && !(MDCtrl[1] && BusB == 32'd0);
            r_neg  <= signed_op && BusA[31];
        end else if (state == CALC) begin
            if (is_div) begin
                acc_hi <= div_ge ? div_diff : div_shift[31:0];
                acc_lo <= {acc_lo[30:0], div_ge};
            end else begin
                acc_hi <= mul_sum[32:1];
                acc_lo <= {mul_sum[0], acc_lo[31:1]};
            end
        end else if (state == FIX && cnt == 5'd0) begin
            if (is_div) begin
                acc_hi <= negate32(acc_hi, r_neg);
                acc_lo <= negate32(acc_lo, q_neg);
            end else begin
                acc_hi <= prod_fixed[63:32];
                acc_lo <= prod_fixed[31:0];
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of complete operations plus
// hand-written sequences for flush, restart-while-busy and reset corner cases.
module tb_mult_div_unit;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [31:0] BusA, BusB;
    logic [2:0]  MDCtrl;
    logic        Start, Flush;
    logic        Busy, Done;
    logic [31:0] HiLoOut;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    mult_div_unit dut (
        .CLK    (CLK),
        .Reset_L(Reset_L),
        .BusA   (BusA),
        .BusB   (BusB),
        .MDCtrl (MDCtrl),
        .Start  (Start),
        .Flush  (Flush),
        .Busy   (Busy),
        .Done   (Done),
        .HiLoOut(HiLoOut)
    );

    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        MDCtrl = 3'b100;
        #1 h = HiLoOut;
        MDCtrl = 3'b101;
        #1 l = HiLoOut;
    endtask

    task automatic move_to(input logic [2:0] ctrl, input logic [31:0] val);
        @(negedge CLK);
        MDCtrl = ctrl; BusA = val; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0; MDCtrl = 3'b101;
    endtask

    // Count Busy/Done activity over a window of n cycles
    task automatic watch(input int n, output int busy_cnt, output int done_cnt);
        busy_cnt = 0; done_cnt = 0;
        repeat (n) begin
            if (Busy === 1'b1) busy_cnt++;
            if (Done === 1'b1) done_cnt++;
            @(negedge CLK);
        end
    endtask

    task automatic run_op(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cyc, output int done_cnt, output logic done_first);
        @(negedge CLK);
        MDCtrl = ctrl; BusA = a; BusB = b; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0; BusA = ~a; BusB = b ^ 32'h0F0F_0F0F; MDCtrl = 3'b101;
        busy_cyc = 0; done_cnt = 0;
        while (Busy === 1'b1 && busy_cyc < 100) begin
            busy_cyc++;
            if (Done === 1'b1) done_cnt++;
            @(negedge CLK);
        end
        done_first = Done;
        repeat (3) begin
            if (Done === 1'b1) done_cnt++;
            @(negedge CLK);
        end
    endtask

    initial begin
        logic [31:0] h, l;
        int          bc, dc, cyc;
        logic        df;

        vecs[0] = '{"mult_neg2x3",     3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{"multu_max",       3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{"div_neg7_2",      3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"divu_7_0",        3'b011, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4] = '{"div_min_neg1",    3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{"mult_max_min",    3'b000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        vecs[6] = '{"divu_100_7",      3'b011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[7] = '{"div_7_neg2",      3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8] = '{"div_neg7_0",      3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9] = '{"multu_2p16",      3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

        Reset_L = 1'b0; Start = 1'b0; Flush = 1'b0;
        MDCtrl = 3'b101; BusA = 32'h0; BusB = 32'h0;
        repeat (2) @(negedge CLK);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        read_hilo(h, l);
        check("reset_hi", h, 32'h0);
        check("reset_lo", l, 32'h0);
        Reset_L = 1'b1;

        // MTLO/MTHI write immediately without Busy
        move_to(3'b111, 32'h1234_5678);
        check("mtlo_busy", {31'd0, Busy}, 32'd0);
        check("mtlo_done", {31'd0, Done}, 32'd0);
        MDCtrl = 3'b101;
        #1 check("mflo_value", HiLoOut, 32'h1234_5678);
        move_to(3'b110, 32'hAAAA_0000);
        read_hilo(h, l);
        check("mthi_hi", h, 32'hAAAA_0000);
        check("mthi_lo", l, 32'h1234_5678);

        // Flush beats Start, and MFHI with Start does nothing
        @(negedge CLK);
        MDCtrl = 3'b111; BusA = 32'hDEAD_BEEF; Start = 1'b1; Flush = 1'b1;
        @(negedge CLK);
        MDCtrl = 3'b000; BusA = 32'd3; BusB = 32'd3;
        @(negedge CLK);
        check("flush_start_busy", {31'd0, Busy}, 32'd0);
        Flush = 1'b0; MDCtrl = 3'b100;
        @(negedge CLK);
        Start = 1'b0;
        check("mfhi_start_busy", {31'd0, Busy}, 32'd0);
        read_hilo(h, l);
        check("flush_start_lo", l, 32'h1234_5678);
        check("flush_start_hi", h, 32'hAAAA_0000);

        foreach (vecs[i]) begin
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, bc, dc, df);
            read_hilo(h, l);
            check({vecs[i].name, "_hi"}, h, vecs[i].hi);
            check({vecs[i].name, "_lo"}, l, vecs[i].lo);
            check({vecs[i].name, "_busy_cycles"}, 32'(bc), 32'd34);
            check({vecs[i].name, "_done_count"}, 32'(dc), 32'd1);
            check({vecs[i].name, "_done_timing"}, {31'd0, df}, 32'd1);
        end

        // Start while busy is ignored
        @(negedge CLK);
        MDCtrl = 3'b001; BusA = 32'd3; BusB = 32'd5; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        cyc = 0; dc = 0;
        while (Busy === 1'b1 && cyc < 100) begin
            if (cyc == 4) begin
                MDCtrl = 3'b011; BusA = 32'd1000; BusB = 32'd10; Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            if (Done === 1'b1) dc++;
            cyc++;
            @(negedge CLK);
        end
        Start = 1'b0;
        if (Done === 1'b1) dc++;
        read_hilo(h, l);
        check("restart_busy_cycles", 32'(cyc), 32'd34);
        check("restart_hi", h, 32'h0);
        check("restart_lo", l, 32'd15);
        check("restart_done", 32'(dc), 32'd1);

        // Flush mid-divide after an ignored second Start
        move_to(3'b111, 32'h1234_5678);
        move_to(3'b110, 32'hAAAA_0000);
        @(negedge CLK);
        MDCtrl = 3'b010; BusA = 32'd100; BusB = 32'd7; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (4) @(negedge CLK);
        MDCtrl = 3'b010; BusA = 32'd55; BusB = 32'd3; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (14) @(negedge CLK);
        check("flush_mid_busy_before", {31'd0, Busy}, 32'd1);
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        check("flush_mid_busy_after", {31'd0, Busy}, 32'd0);
        watch(40, bc, dc);
        check("flush_mid_busy_window", 32'(bc), 32'd0);
        check("flush_mid_done_window", 32'(dc), 32'd0);
        read_hilo(h, l);
        check("flush_mid_hi", h, 32'hAAAA_0000);
        check("flush_mid_lo", l, 32'h1234_5678);

        // Flush during the final FIX cycle aborts the write
        @(negedge CLK);
        MDCtrl = 3'b001; BusA = 32'd6; BusB = 32'd7; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0; MDCtrl = 3'b101;
        repeat (33) @(negedge CLK);
        check("flush_fix_busy_before", {31'd0, Busy}, 32'd1);
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        check("flush_fix_busy_after", {31'd0, Busy}, 32'd0);
        watch(5, bc, dc);
        check("flush_fix_done_window", 32'(dc), 32'd0);
        read_hilo(h, l);
        check("flush_fix_hi", h, 32'hAAAA_0000);
        check("flush_fix_lo", l, 32'h1234_5678);

        // Reset pulsed mid-multiply
        @(negedge CLK);
        MDCtrl = 3'b000; BusA = 32'd9; BusB = 32'd9; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (10) @(negedge CLK);
        Reset_L = 1'b0;
        #1;
        check("reset_mid_busy", {31'd0, Busy}, 32'd0);
        check("reset_mid_done", {31'd0, Done}, 32'd0);
        read_hilo(h, l);
        check("reset_mid_hi", h, 32'h0);
        check("reset_mid_lo", l, 32'h0);
        @(negedge CLK);
        Reset_L = 1'b1;
        watch(40, bc, dc);
        check("reset_mid_busy_window", 32'(bc), 32'd0);
        check("reset_mid_done_window", 32'(dc), 32'd0);
        read_hilo(h, l);
        check("reset_mid_lo_after", l, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
